// File: rtl/ro_puf_controller_if.sv
// ---------------------------------------------------------------------------
// ro_puf_controller_if
// Host-side request/response bundle of the RO PUF controller.
//   start       request pulse (host -> controller)
//   abort       synchronous abort (host -> controller)
//   challenge   8 bits per response bit: [3:0]=Cha0 index, [7:4]=Cha1 index
//   busy        controller is not idle
//   resp_valid  response word available
//   resp_ready  host accepts the response word
//   response    N_BITS-bit response word
//   err         sticky flag: some slice selected the same RO twice
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface ro_puf_controller_if #(
    parameter int N_BITS = 8
);
    logic                  start;
    logic                  abort;
    logic [8*N_BITS-1:0]   challenge;
    logic                  busy;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [N_BITS-1:0]     response;
    logic                  err;

    modport master (
        output start, abort, challenge, resp_ready,
        input  busy, resp_valid, response, err
    );

    modport slave (
        input  start, abort, challenge, resp_ready,
        output busy, resp_valid, response, err
    );
endinterface

// File: rtl/ro_puf_controller.sv
// ---------------------------------------------------------------------------
// ro_puf_controller
// Sequencer for the 16-RO counter-group PUF. For each challenge slice it
// selects an RO pair, clears the counter group, runs the ROs for a fixed
// window, lets the race result settle through a synchronizer and captures
// one response bit. The full word is handed back over valid/ready.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   host         host request/response bundle (slave modport)
//   cnt_reset    active-high reset to the counter group
//   ro_en        RO array enable
//   cha0, cha1   RO pair selects to the counter group
//   cg_response  race result from the counter group, asynchronous to clk
// ---------------------------------------------------------------------------
module ro_puf_controller #(
    parameter int N_BITS        = 8,
    parameter int EVAL_CYCLES   = 1024,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    ro_puf_controller_if.slave   host,
    output logic                 cnt_reset,
    output logic                 ro_en,
    output logic [3:0]           cha0,
    output logic [3:0]           cha1,
    input  logic                 cg_response
);

    localparam int MAX_AB     = (EVAL_CYCLES > RST_CYCLES) ? EVAL_CYCLES : RST_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EVAL,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [TIMER_W-1:0]   timer_load;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [8*N_BITS-1:0]  ch_reg;
    logic [N_BITS-1:0]    response_reg;
    logic                 err_reg;
    logic                 resp_valid_reg;
    logic [1:0]           sync_reg;
    logic                 busy;

    logic [3:0]           slice_a [N_BITS];
    logic [3:0]           slice_b [N_BITS];
    logic [3:0]           sel_a;
    logic [3:0]           sel_b;
    logic                 last_bit;
    logic                 accept;

    // Split the latched challenge into per-bit RO index pairs.
    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_slice
            assign slice_a[gi] = ch_reg[8*gi +: 4];
            assign slice_b[gi] = ch_reg[8*gi+4 +: 4];
        end
    endgenerate

    assign sel_a    = slice_a[bit_idx_reg];
    assign sel_b    = slice_b[bit_idx_reg];
    assign last_bit = (bit_idx_reg == IDX_W'(N_BITS - 1));
    assign accept   = (state_reg == S_IDLE) && host.start && !host.abort;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (host.start)         state_next = S_CLEAR;
            S_CLEAR:   if (timer_reg == '0)    state_next = S_EVAL;
            S_EVAL:    if (timer_reg == '0)    state_next = S_SETTLE;
            S_SETTLE:  if (timer_reg == '0)    state_next = S_CAPTURE;
            S_CAPTURE: state_next = last_bit ? S_DONE : S_CLEAR;
            S_DONE:    if (resp_valid_reg && host.resp_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE.
        if (host.abort) begin
            state_next = S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy      = 1'b1;
        cnt_reset = 1'b1;
        ro_en     = 1'b0;
        cha0      = 4'd0;
        cha1      = 4'd0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CLEAR: begin
                cha0 = sel_a;
                cha1 = sel_b;
            end
            S_EVAL: begin
                cnt_reset = 1'b0;
                ro_en     = 1'b1;
                cha0      = sel_a;
                cha1      = sel_b;
            end
            S_SETTLE, S_CAPTURE: begin
                cnt_reset = 1'b0;
                cha0      = sel_a;
                cha1      = sel_b;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Phase timer: loaded with (duration-1) on entry to a state, counts down
    // to zero, and the state is left on the zero cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        timer_load = '0;
        case (state_next)
            S_CLEAR:  timer_load = TIMER_W'(RST_CYCLES - 1);
            S_EVAL:   timer_load = TIMER_W'(EVAL_CYCLES - 1);
            S_SETTLE: timer_load = TIMER_W'(SETTLE_CYCLES - 1);
            default:  timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg <= '0;
        end else if (state_next != state_reg) begin
            timer_reg <= timer_load;
        end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - TIMER_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: synchronizer, challenge latch, response assembly, handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg       <= 2'b00;
            ch_reg         <= '0;
            response_reg   <= '0;
            err_reg        <= 1'b0;
            bit_idx_reg    <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], cg_response};

            if (accept) begin
                ch_reg       <= host.challenge;
                response_reg <= '0;
                err_reg      <= 1'b0;
                bit_idx_reg  <= '0;
            end

            // An aborted CAPTURE cycle leaves the partial word untouched.
            if (state_reg == S_CAPTURE && !host.abort) begin
                if (sel_a == sel_b) begin
                    // Identical ROs cannot race; force 0 and flag it.
                    response_reg[bit_idx_reg] <= 1'b0;
                    err_reg                   <= 1'b1;
                end else begin
                    response_reg[bit_idx_reg] <= sync_reg[1];
                end
                if (!last_bit) begin
                    bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                end
            end

            // Valid rises on the second DONE cycle and stays until transfer
            // or abort; both of those drive state_next away from DONE.
            resp_valid_reg <= (state_reg == S_DONE) && (state_next == S_DONE);
        end
    end

    assign host.busy       = busy;
    assign host.resp_valid = resp_valid_reg;
    assign host.response   = response_reg;
    assign host.err        = err_reg;

endmodule
